// File: rtl/dec7seg_scan.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one decoder.
// Each slot has a blank phase before the anode turns on; words commit only at frame boundaries.
module dec7seg_scan #(
  parameter int N_DIGITS  = 4,
  parameter int DIV_CNT   = 50000,
  parameter int BLANK_CNT = 500
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic                    lzb_en_i,
  input  logic                    load_i,
  input  logic [4*N_DIGITS-1:0]   data_i,
  output logic [3:0]              bcd_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int CW = $clog2(DIV_CNT);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CNT - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV_CNT - 1);
  localparam logic [IW-1:0] LAST_DIG   = IW'(N_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                   state, state_nx;
  logic [CW-1:0]            cnt, cnt_nx;
  logic [IW-1:0]            idx, idx_nx;
  logic [N_DIGITS-1:0][3:0] active, active_nx, shadow;
  logic                     frame_end;
  logic [N_DIGITS:0]        zero_up;
  logic [N_DIGITS-1:0]      lead_zero;
  logic                     blanked;

  // zero_up[k]: digits N_DIGITS-1..k of the active word are all zero
  assign zero_up[N_DIGITS] = 1'b1;
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_lz
    assign zero_up[k] = zero_up[k+1] & (active[k] == 4'h0);
  end
  assign lead_zero = zero_up[N_DIGITS-1:0];
  assign blanked   = lzb_en_i && (idx != '0) && lead_zero[idx];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= BLANK;
      cnt       <= '0;
      idx       <= '0;
      active    <= '0;
      shadow    <= '0;
      pending_o <= 1'b0;
      bcd_o     <= 4'h0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      active <= active_nx;
      if (load_i) shadow <= data_i;
      if (frame_end)   pending_o <= 1'b0;
      else if (load_i) pending_o <= 1'b1;
      // decoder input settles during the blank phase, ahead of the anode
      if (state_nx == BLANK) bcd_o <= active_nx[idx_nx];
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    active_nx = active;
    frame_end = 1'b0;
    if (!en_i) begin
      state_nx = BLANK;
      cnt_nx   = '0;
    end else begin
      cnt_nx = cnt + 1'b1;
      case (state)
        BLANK: if (cnt == BLANK_LAST) state_nx = SHOW;
        SHOW: if (cnt == SLOT_LAST) begin
          state_nx  = BLANK;
          cnt_nx    = '0;
          idx_nx    = (idx == LAST_DIG) ? '0 : idx + 1'b1;
          frame_end = (idx == LAST_DIG);
        end
        default: state_nx = BLANK;
      endcase
    end
    // a load landing on the frame-end cycle goes straight to the active word
    if (frame_end) begin
      if (load_i)         active_nx = data_i;
      else if (pending_o) active_nx = shadow;
    end
  end

  assign frame_o = frame_end;

  always_comb begin
    an_o = '1;
    if (state == SHOW && !blanked) an_o[idx] = 1'b0;
  end

endmodule

// File: tb/tb_dec7seg_scan.sv
// Bench for dec7seg_scan: slot-position reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dec7seg_scan;
  localparam int N = 4, DIV = 8, BLK = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, lzb_en = 1'b0, load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  bcd, an;
  logic        frame, pending;

  dec7seg_scan #(.N_DIGITS(N), .DIV_CNT(DIV), .BLANK_CNT(BLK)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .lzb_en_i(lzb_en), .load_i(load),
    .data_i(data), .bcd_o(bcd), .an_o(an), .frame_o(frame), .pending_o(pending));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: position within the current digit slot, plus the word bookkeeping
  int          m_pos = 0, m_dig = 0;
  logic [15:0] m_act = '0, m_shd = '0;
  logic        m_pend = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_dig = 0; m_act = '0; m_shd = '0; m_pend = 1'b0;
    end else begin
      if (en && m_pos == DIV-1 && m_dig == N-1) begin
        if (load)        m_act = data;
        else if (m_pend) m_act = m_shd;
        m_pend = 1'b0;
      end else if (load) m_pend = 1'b1;
      if (load) m_shd = data;
      if (!en) m_pos = 0;
      else if (m_pos == DIV-1) begin m_pos = 0; m_dig = (m_dig + 1) % N; end
      else m_pos++;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic       blk;
      logic [3:0] e_an;
      blk  = lzb_en && m_dig != 0 && ((m_act >> (4*m_dig)) == 16'h0);
      e_an = (m_pos >= BLK && !blk) ? ~(4'b0001 << m_dig) : 4'hF;
      chk("an_o", an, e_an);
      chk("bcd_o", bcd, 4'((m_act >> (4*m_dig)) & 16'hF));
      chk("frame_o", frame, en && m_pos == DIV-1 && m_dig == N-1);
      chk("pending_o", pending, m_pend);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_frame(output int n);
    bit found = 1'b0;
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame) begin n = i; found = 1'b1; break; end
    end
    chk("frame_seen", found, 1);
  endtask

  task automatic wait_an(input logic [3:0] v);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an == v) begin found = 1'b1; break; end
    end
    chk("anode_seen", found, 1);
  endtask

  int         cap_low[4];
  logic [3:0] cap_bcd[4];
  int         cap_ones;

  // sample the next full frame (32 cycles) starting at the next negedge
  task automatic capture();
    cap_ones = 0;
    for (int d = 0; d < 4; d++) begin cap_low[d] = 0; cap_bcd[d] = 4'h0; end
    repeat (N*DIV) begin
      @(negedge clk);
      if (an == 4'hF) cap_ones++;
      for (int d = 0; d < 4; d++)
        if (an == ~(4'b0001 << d)) begin cap_low[d]++; cap_bcd[d] = bcd; end
    end
  endtask

  initial begin
    int n;
    logic [3:0] seq [8];
    // reset held while inputs wiggle
    for (int i = 0; i < 4; i++) begin
      en = i[0]; load = ~i[0]; lzb_en = i[1]; data = 16'h1234 + 16'(i);
      @(negedge clk);
      chk("rst_an", an, 4'hF); chk("rst_bcd", bcd, 4'h0);
      chk("rst_frame", frame, 0); chk("rst_pend", pending, 0);
    end
    en = 0; load = 0; lzb_en = 0; data = '0;
    step(); rst_n = 1'b1; chk_on = 1'b1;
    repeat (20) step();
    chk("dark_an", an, 4'hF);

    // enable, load 1234 at cycle 3; first frame_o at cycle 31
    en = 1;
    repeat (3) step();
    load = 1; data = 16'h1234; step(); load = 0;
    @(negedge clk); chk("pend_after_load", pending, 1);
    wait_frame(n); chk("first_frame_cycle", n, 26);
    chk("pend_at_frame", pending, 1);
    capture();
    chk("pend_cleared", pending, 0);
    chk("ones_1234", cap_ones, 8);
    chk("low0", cap_low[0], 6); chk("low1", cap_low[1], 6);
    chk("low2", cap_low[2], 6); chk("low3", cap_low[3], 6);
    chk("bcd0_4", cap_bcd[0], 4'h4); chk("bcd1_3", cap_bcd[1], 4'h3);
    chk("bcd2_2", cap_bcd[2], 4'h2); chk("bcd3_1", cap_bcd[3], 4'h1);

    // leading-zero blanking on 0050
    step(); lzb_en = 1; load = 1; data = 16'h0050; step(); load = 0;
    wait_frame(n);
    capture();
    chk("lz_low3", cap_low[3], 0); chk("lz_low2", cap_low[2], 0);
    chk("lz_low1", cap_low[1], 6); chk("lz_low0", cap_low[0], 6);
    chk("lz_bcd1", cap_bcd[1], 4'h5); chk("lz_bcd0", cap_bcd[0], 4'h0);
    chk("lz_ones", cap_ones, 20);
    step(); lzb_en = 0;
    wait_frame(n);
    capture();
    chk("nolz_low3", cap_low[3], 6); chk("nolz_low2", cap_low[2], 6);

    // last load before frame end wins
    step(); repeat (5) step();
    load = 1; data = 16'hABCD; step(); load = 0;
    repeat (5) step();
    load = 1; data = 16'hBEEF; step(); load = 0;
    @(negedge clk); chk("pend_two_loads", pending, 1);
    wait_frame(n);
    capture();
    chk("beef0", cap_bcd[0], 4'hF); chk("beef1", cap_bcd[1], 4'hE);
    chk("beef2", cap_bcd[2], 4'hE); chk("beef3", cap_bcd[3], 4'hB);

    // enable drop during digit 2 SHOW, then restart of that slot
    wait_an(4'b1011);
    step(); en = 0;
    step(); @(negedge clk); chk("drop_an", an, 4'hF);
    repeat (3) step();
    step(); en = 1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); seq[i] = an; end
    chk("restart_b0", seq[0], 4'hF); chk("restart_b1", seq[1], 4'hF);
    for (int i = 2; i < 8; i++) chk("restart_show", seq[i], 4'b1011);

    // load coincident with frame end bypasses the shadow
    wait_frame(n);
    repeat (N*DIV) @(posedge clk); #1;
    load = 1; data = 16'h9876;
    @(negedge clk); chk("bypass_frame", frame, 1);
    @(posedge clk); #1; load = 0;
    capture();
    chk("bypass_pend", pending, 0);
    chk("byp0", cap_bcd[0], 4'h6); chk("byp1", cap_bcd[1], 4'h7);
    chk("byp2", cap_bcd[2], 4'h8); chk("byp3", cap_bcd[3], 4'h9);

    // asynchronous reset mid-SHOW with a word pending
    step(); load = 1; data = 16'h1111; step(); load = 0;
    wait_an(4'b1110);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'hF); chk("arst_bcd", bcd, 4'h0);
    chk("arst_frame", frame, 0); chk("arst_pend", pending, 0);
    step(); rst_n = 1'b1;

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      step();
      en   = ($urandom % 20) != 0;
      if (($urandom % 50) == 0) lzb_en = ~lzb_en;
      load = ($urandom % 40) == 0;
      data = 16'($urandom);
      if ($urandom % 2) data = data >> (4 * ($urandom % 4));
    end
    load = 0;
    repeat (2) step();
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
